// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: NOP word and controller states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package icache_pkg;

    // Word returned whenever no valid instruction is delivered.
    localparam logic [31:0] NOP = 32'b0;

    // Controller states, kept as plain constants so older tools can consume them.
    typedef logic [1:0] icache_state_e;
    localparam icache_state_e IDLE = 2'd0;
    localparam icache_state_e REQ  = 2'd1;
    localparam icache_state_e DATA = 2'd2;

endpackage

// File: rtl/icache_array.sv
// Flop-based line storage: valid bits, tags and data words for a direct-mapped cache.
// Latency: combinational read of (index, word); writes land on the next edge.
// Backpressure: none; the write port is always accepted, clear-all beats set-valid.
module icache_array #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 22
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [$clog2(NUM_LINES)-1:0]  rd_idx_i,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_word_i,
    output logic                          rd_valid_o,
    output logic [TAG_W-1:0]              rd_tag_o,
    output logic [31:0]                   rd_data_o,
    input  logic                          wr_en_i,
    input  logic [$clog2(NUM_LINES)-1:0]  wr_idx_i,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_word_i,
    input  logic [31:0]                   wr_data_i,
    input  logic                          set_valid_i,
    input  logic [TAG_W-1:0]              wr_tag_i,
    input  logic                          clr_all_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i][rd_word_i];

    // Valid bits: reset and clear-all win over marking a freshly filled line valid.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_all_i) begin
            valid_q <= '0;
        end else if (wr_en_i && set_valid_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data payload; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            data_q[wr_idx_i][wr_word_i] <= wr_data_i;
            if (set_valid_i) begin
                tag_q[wr_idx_i] <= wr_tag_i;
            end
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with whole-line burst refill.
// Latency: hit answered the cycle after the request; a miss answers two cycles after the last beat.
// Backpressure: refill request held stable until mem_req_ready_i; beats accepted whenever valid.
module icache
    import icache_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ic_req_valid_i,
    input  logic [31:0] ic_req_addr_i,
    output logic        ic_rsp_valid_o,
    output logic [31:0] ic_rsp_data_o,
    input  logic        ic_inv_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_data_i
);

    localparam int WOFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int LSB_W  = WOFF_W + 2;
    localparam int TAG_W  = 32 - LSB_W - IDX_W;
    localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(LINE_WORDS - 1);

    icache_state_e     state_q, state_d;
    logic [WOFF_W-1:0] cnt_q, cnt_d;
    logic              inv_pend_q, inv_pend_d;
    logic              rsp_vld_q, rsp_vld_d;
    logic [31:0]       rsp_dat_q, rsp_dat_d;
    logic              mem_req_vld_q, mem_req_vld_d;
    logic [31:0]       mem_req_addr_q, mem_req_addr_d;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [31:0]       rd_data;
    logic              hit;
    logic              wr_en;
    logic              set_valid;
    logic              clr_all;

    // Byte-select bits never influence the lookup.
    logic unused_byte_bits;
    assign unused_byte_bits = ^ic_req_addr_i[1:0];

    // Lookups always use the live fetch address; writes always target the latched refill line.
    icache_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_idx_i    (ic_req_addr_i[LSB_W +: IDX_W]),
        .rd_word_i   (ic_req_addr_i[2 +: WOFF_W]),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .wr_en_i     (wr_en),
        .wr_idx_i    (mem_req_addr_q[LSB_W +: IDX_W]),
        .wr_word_i   (cnt_q),
        .wr_data_i   (mem_rsp_data_i),
        .set_valid_i (set_valid),
        .wr_tag_i    (mem_req_addr_q[31 -: TAG_W]),
        .clr_all_i   (clr_all)
    );

    assign hit = rd_valid && (rd_tag == ic_req_addr_i[31 -: TAG_W]);

    // Next-state logic: lookup in IDLE, request handshake in REQ, beat collection in DATA.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        inv_pend_d     = inv_pend_q;
        rsp_vld_d      = 1'b0;
        rsp_dat_d      = NOP;
        mem_req_vld_d  = mem_req_vld_q;
        mem_req_addr_d = mem_req_addr_q;
        wr_en          = 1'b0;
        set_valid      = 1'b0;
        clr_all        = 1'b0;
        case (state_q)
            IDLE: begin
                if (ic_inv_i) begin
                    clr_all = 1'b1;
                end else if (ic_req_valid_i) begin
                    if (hit) begin
                        rsp_vld_d = 1'b1;
                        rsp_dat_d = rd_data;
                    end else begin
                        mem_req_addr_d = {ic_req_addr_i[31:LSB_W], {LSB_W{1'b0}}};
                        mem_req_vld_d  = 1'b1;
                        state_d        = REQ;
                    end
                end
            end
            REQ: begin
                if (ic_inv_i) begin
                    inv_pend_d = 1'b1;
                end
                if (mem_req_ready_i) begin
                    mem_req_vld_d = 1'b0;
                    cnt_d         = '0;
                    state_d       = DATA;
                end
            end
            DATA: begin
                if (ic_inv_i) begin
                    inv_pend_d = 1'b1;
                end
                if (mem_rsp_valid_i) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        // A fence seen during the refill also kills the line just filled.
                        set_valid  = 1'b1;
                        clr_all    = inv_pend_q || ic_inv_i;
                        inv_pend_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            inv_pend_q     <= 1'b0;
            rsp_vld_q      <= 1'b0;
            rsp_dat_q      <= NOP;
            mem_req_vld_q  <= 1'b0;
            mem_req_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            inv_pend_q     <= inv_pend_d;
            rsp_vld_q      <= rsp_vld_d;
            rsp_dat_q      <= rsp_dat_d;
            mem_req_vld_q  <= mem_req_vld_d;
            mem_req_addr_q <= mem_req_addr_d;
        end
    end

    assign ic_rsp_valid_o  = rsp_vld_q;
    assign ic_rsp_data_o   = rsp_dat_q;
    assign mem_req_valid_o = mem_req_vld_q;
    assign mem_req_addr_o  = mem_req_addr_q;

endmodule

// File: tb/tb_icache.sv
// Testbench for icache: directed scenarios followed by randomized fetch traffic.
// Latency: expectations derived from a line-level model of cache contents and backing memory.
// Backpressure: the bench plays the memory, stalling the grant and spacing beats at random.
module tb_icache;

    localparam int NL = 64;
    localparam int LW = 4;
    localparam logic [31:0] NO_REDIR = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ic_req_valid = 1'b0;
    logic [31:0] ic_req_addr = '0;
    logic        ic_rsp_valid;
    logic [31:0] ic_rsp_data;
    logic        ic_inv = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;

    int checks = 0;
    int errors = 0;

    // Reference model: which line holds which tag.
    bit          m_valid [NL];
    logic [31:0] m_tag   [NL];

    icache #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ic_req_valid_i  (ic_req_valid),
        .ic_req_addr_i   (ic_req_addr),
        .ic_rsp_valid_o  (ic_rsp_valid),
        .ic_rsp_data_o   (ic_rsp_data),
        .ic_inv_i        (ic_inv),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_data_i  (mem_rsp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Backing memory contents: a known pattern at 0x100 and a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h100 && a < 32'h110) return 32'hA0 + (a - 32'h100) / 4;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    function automatic int line_idx(input logic [31:0] a);
        return int'((a / (LW * 4)) % NL);
    endfunction

    function automatic logic [31:0] line_tag(input logic [31:0] a);
        return a / (LW * 4 * NL);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[line_idx(a)] && (m_tag[line_idx(a)] == line_tag(a));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rsp_vld"}, ic_rsp_valid, 1'b0);
        chk({tag, "_rsp_dat"}, ic_rsp_data, 32'h0);
    endtask

    task automatic idle();
        ic_req_valid = 1'b0;
        tick();
        chk_quiet("idle");
        chk("idle_req", mem_req_valid, 1'b0);
    endtask

    // Invalidate while presenting a request: no response and no refill may follow.
    task automatic inv_idle(input logic [31:0] a);
        ic_req_valid = 1'b1;
        ic_req_addr  = a;
        ic_inv       = 1'b1;
        tick();
        ic_inv = 1'b0;
        chk_quiet("inv");
        chk("inv_noreq", mem_req_valid, 1'b0);
        model_clear();
    endtask

    // One fetch of address a, playing memory for any refill it causes.
    task automatic fetch(input logic [31:0] a, input int rdy_dly = 0, input int gap_max = 0,
                         input logic [31:0] redir = NO_REDIR, input int inv_beat = -1,
                         input int rst_beat = -1);
        logic [31:0] line;
        int gap;
        ic_req_valid = 1'b1;
        ic_req_addr  = a;
        if (model_hit(a)) begin
            tick();
            chk("hit_vld", ic_rsp_valid, 1'b1);
            chk("hit_dat", ic_rsp_data, mem_word(a));
            chk("hit_noreq", mem_req_valid, 1'b0);
            return;
        end
        line = a - (a % (LW * 4));
        tick();
        chk_quiet("miss");
        chk("req_vld", mem_req_valid, 1'b1);
        chk("req_addr", mem_req_addr, line);
        for (int i = 0; i < rdy_dly; i++) begin
            // A stray beat before the grant must be ignored.
            mem_rsp_valid = (i == 0);
            mem_rsp_data  = 32'hBAD0_0000;
            tick();
            chk("stall_vld", mem_req_valid, 1'b1);
            chk("stall_addr", mem_req_addr, line);
            chk_quiet("stall");
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("req_drop", mem_req_valid, 1'b0);
        chk_quiet("grant");
        if (redir != NO_REDIR) ic_req_addr = redir;
        for (int w = 0; w < LW; w++) begin
            gap = $urandom_range(gap_max, 0);
            repeat (gap) begin
                tick();
                chk_quiet("gap");
            end
            if (w == rst_beat) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                ic_req_valid = 1'b0;
                chk_quiet("rst");
                chk("rst_req_vld", mem_req_valid, 1'b0);
                chk("rst_req_addr", mem_req_addr, 32'h0);
                model_clear();
                for (int k = w; k < LW; k++) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_word(line + 4 * k);
                    tick();
                    chk_quiet("late");
                    chk("late_noreq", mem_req_valid, 1'b0);
                end
                mem_rsp_valid = 1'b0;
                return;
            end
            ic_inv        = (w == inv_beat);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(line + 4 * w);
            tick();
            ic_inv        = 1'b0;
            mem_rsp_valid = 1'b0;
            chk_quiet("beat");
        end
        m_valid[line_idx(line)] = 1'b1;
        m_tag[line_idx(line)]   = line_tag(line);
        if (inv_beat >= 0) model_clear();
        if (redir != NO_REDIR || inv_beat >= 0) return;
        tick();
        chk("fill_vld", ic_rsp_valid, 1'b1);
        chk("fill_dat", ic_rsp_data, mem_word(a));
    endtask

    initial begin
        int unsigned r;
        logic [31:0] a;
        model_clear();

        // Reset values.
        repeat (3) tick();
        chk_quiet("reset");
        chk("reset_req_vld", mem_req_valid, 1'b0);
        chk("reset_req_addr", mem_req_addr, 32'h0);
        rst = 1'b0;

        // First miss and refill, then back-to-back hits on the same line.
        fetch(32'h100);
        fetch(32'h104);
        fetch(32'h108);
        fetch(32'h10C);

        // Conflict on the same index with a different tag, then the original misses again.
        fetch(32'h500);
        fetch(32'h100);

        // Grant withheld for three cycles.
        fetch(32'h500, 3);

        // Redirect during the refill: no response for the stale line.
        fetch(32'h100, 0, 0, 32'h200);
        fetch(32'h200);

        // Invalidate together with a hit: invalidate wins, then the line misses.
        inv_idle(32'h200);
        fetch(32'h200);

        // Invalidate during DATA kills the refilled line too.
        fetch(32'h100, 1, 0, NO_REDIR, 2);
        fetch(32'h100);

        // Reset in the middle of a refill, then everything misses again.
        fetch(32'h300, 0, 0, NO_REDIR, -1, 2);
        idle();
        fetch(32'h300);
        fetch(32'h100);

        // Randomized traffic over a small address set with conflicting tags.
        repeat (80) begin
            r = $urandom_range(0, 11);
            a = ($urandom_range(1, 2) * 1024) + ($urandom_range(0, 7) * 16) + ($urandom_range(0, 3) * 4);
            if (r == 0) inv_idle(a);
            else if (r == 1) idle();
            else if (r == 2) fetch(a, $urandom_range(0, 3), 2, NO_REDIR, $urandom_range(0, LW - 1));
            else fetch(a, $urandom_range(0, 3), 2);
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache sitting between the fetch stage and the backing memory. It answers fetch's level-sensitive instruction request, returning a hit one cycle later. On a miss it refills the whole line from backing memory with a single request followed by an in-order beat burst, then answers from the refilled line. Returns NOP (32'b0) whenever no valid instruction is delivered.

## Interface
- NUM_LINES, 64: number of cache lines; power of two, ≥2.
- LINE_WORDS, 4: 32-bit words per line; power of two, ≥2.
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous, active-high reset.
- ic_req_valid_i  in  1  fetch requests the instruction at ic_req_addr_i this cycle.
- ic_req_addr_i  in  32  byte address; bits [1:0] ignored.
- ic_rsp_valid_o  out  1  ic_rsp_data_o holds the instruction for the address accepted the previous cycle.
- ic_rsp_data_o  out  32  instruction word; 32'b0 whenever ic_rsp_valid_o=0.
- ic_inv_i  in  1  invalidate all lines (fence.i).
- mem_req_valid_o  out  1  line refill request.
- mem_req_ready_i  in  1  backing memory accepts the request.
- mem_req_addr_o  out  32  line-aligned refill address; low log2(LINE_WORDS)+2 bits are zero.
- mem_rsp_valid_i  in  1  one refill beat present.
- mem_rsp_data_i  in  32  refill word; beats arrive in word order 0..LINE_WORDS-1.

## Operation
- Address split: [1:0] byte (ignored) | WOFF=log2(LINE_WORDS) word offset | IDX=log2(NUM_LINES) index | tag = remaining upper bits.
- Storage per line: valid bit, tag, LINE_WORDS data words, all in flops.
- FSM states:
  - IDLE: combinational lookup of ic_req_addr_i.
    - Hit with ic_req_valid_i=1 and ic_inv_i=0: register the word and raise ic_rsp_valid_o next cycle.
    - Miss with ic_req_valid_i=1 and ic_inv_i=0: latch the line address and go to REQ.
  - REQ: hold mem_req_valid_o=1 with a stable mem_req_addr_o until mem_req_ready_i=1, then go to DATA with the beat counter at 0.
  - DATA: on each mem_rsp_valid_i, write the beat to word[counter] and increment the counter. On the last beat, write the tag, set the valid bit, and go to IDLE.
- ic_rsp_valid_o is 0 in REQ and DATA, and in any IDLE cycle without a hit.
- Fetch re-presents its address every cycle; after the refill the same address hits. No response is ever generated for an address that did not hit in IDLE.
- Fetch changes or drops its request during a refill (redirect): the refill runs to completion, since the burst cannot be aborted, and no response is issued for the stale line. The new address is looked up in IDLE.
- ic_inv_i in IDLE: all valid bits clear on the next edge. That cycle gives no response and starts no refill.
- ic_inv_i in REQ or DATA: sets inv_pending. At refill completion all valid bits clear, including the just-filled line, and inv_pending clears.
- Replacement: direct-mapped. A refill overwrites the indexed line unconditionally.
- mem_rsp_valid_i outside DATA is ignored.

## Timing
- Reset values: state=IDLE, all valid bits=0, counter=0, inv_pending=0, ic_rsp_valid_o=0, ic_rsp_data_o=0, mem_req_valid_o=0, mem_req_addr_o=0.
- Hit latency: request in cycle N → response in cycle N+1. Back-to-back hits give one response per cycle.
- Miss sequence:
  - Miss in cycle N → mem_req_valid_o=1 from N+1.
  - Last beat in cycle M → state=IDLE at M+1.
  - Lookup hits at M+1 → response at M+2.
- Reset in any state, including mid-refill: return to reset values on the next edge. The partially written line stays invalid. Late beats are ignored.
- ic_inv_i and a hit in the same IDLE cycle: invalidate wins and no response is given.

## Structure
- Shared core package: NOP constant (32'b0) and icache_state_e {IDLE, REQ, DATA}.
- Sub-module icache_array: valid/tag/data flops with one combinational read port (index, word) and one write port (index, word, data, set_valid), plus a clear-all input. The FSM, counter and response register stay in icache.

## Test plan
- Reset, then request 0x0000_0100 → mem_req_addr_o=0x100. Return beats 0xA0..0xA3 → ic_rsp_valid_o=1 with 0xA0 two cycles after the last beat.
- Then request 0x104, 0x108, 0x10C on consecutive cycles → responses 0xA1, 0xA2, 0xA3 on the following cycles, with no mem_req_valid_o.
- Request 0x500 (same index as 0x100, different tag) → refill at 0x500. A later request to 0x100 misses again.
- mem_req_ready_i held low 3 cycles → mem_req_valid_o and mem_req_addr_o held stable for 4 cycles, with no response during that time.
- Redirect from 0x100 to 0x200 mid-refill → refill of 0x100 completes with no response for it, then refill of 0x200 and a response for 0x200 only.
- ic_inv_i pulsed during DATA → after completion, a request to 0x100 misses. Assert rst_i mid-DATA → all outputs 0 next cycle and further beats are ignored.
